// File: rtl/ctrl_pipe_unit.sv
// ---------------------------------------------------------------------------
// ctrl_pipe_unit
// Pipelined control unit for the 16-bit CPU. Decodes the ID opcode and carries
// MemWrite / MemToReg / RegWrite and the destination register through the
// ID/EX, EX/MEM and MEM/WB slots. It also detects load-use hazards, applies
// flush and stall, and runs the HLT drain state machine.
//
// Parameters
//   REG_ADDR_W  register-file address width
//   HAZARD_EN   1 = generate load-use stalls internally, 0 = stall_lu tied 0
//   HALT_DRAIN  1 = HLT drains to WB before halting, 0 = halt one cycle
//               after HLT enters EX
//
// Ports
//   clk, rst_n                 clock (rising edge), async active-low reset
//   opcode_id, rs_id, rt_id,   instruction fields of the ID instruction
//   rd_id
//   flush_id                   kill the ID instruction (taken branch)
//   stall_ext                  freeze the whole control pipe
//   stall_lu                   load-use stall: hold PC and IF/ID
//   hlt_pend                   HLT in flight (or halted): hold PC
//   halted                     sticky, HLT retired
//   reg_write_ex/mem/wb        RegWrite per stage
//   mem_write_mem              MemWrite in MEM
//   mem_to_reg_wb              MemToReg in WB
//   wr_addr_ex/mem/wb          destination register per stage
// ---------------------------------------------------------------------------
module ctrl_pipe_unit #(
   parameter int REG_ADDR_W = 4,
   parameter int HAZARD_EN  = 1,
   parameter int HALT_DRAIN = 1
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic [3:0]            opcode_id,
   input  logic [REG_ADDR_W-1:0] rs_id,
   input  logic [REG_ADDR_W-1:0] rt_id,
   input  logic [REG_ADDR_W-1:0] rd_id,
   input  logic                  flush_id,
   input  logic                  stall_ext,
   output logic                  stall_lu,
   output logic                  hlt_pend,
   output logic                  halted,
   output logic                  reg_write_ex,
   output logic                  reg_write_mem,
   output logic                  reg_write_wb,
   output logic                  mem_write_mem,
   output logic                  mem_to_reg_wb,
   output logic [REG_ADDR_W-1:0] wr_addr_ex,
   output logic [REG_ADDR_W-1:0] wr_addr_mem,
   output logic [REG_ADDR_W-1:0] wr_addr_wb
);

   typedef enum logic [1:0] {
      S_RUN    = 2'd0,
      S_DRAIN  = 2'd1,
      S_HALTED = 2'd2
   } state_t;

   state_t r_state;
   state_t w_state_nxt;

   // ID decode
   logic w_mw, w_m2r, w_rw, w_hlt, w_src1, w_src2;

   assign w_mw   = (opcode_id == 4'b1001);
   assign w_m2r  = (opcode_id == 4'b1000);
   assign w_hlt  = (opcode_id == 4'b1111);
   assign w_rw   = ~opcode_id[3] | (opcode_id == 4'b1000) | (opcode_id == 4'b1010) |
                   (opcode_id == 4'b1011) | (opcode_id == 4'b1110);
   // B, PCS and HLT do not read source 1
   assign w_src1 = ~((opcode_id == 4'b1100) | (opcode_id == 4'b1110) | (opcode_id == 4'b1111));
   assign w_src2 = (opcode_id[3:2] == 2'b00) | (opcode_id == 4'b0111) | (opcode_id == 4'b1001);

   // ID/EX slot
   logic                  r_vld_ex, r_rw_ex, r_m2r_ex, r_mw_ex, r_hlt_ex;
   logic [REG_ADDR_W-1:0] r_addr_ex;
   // EX/MEM slot
   logic                  r_vld_mem, r_rw_mem, r_m2r_mem, r_mw_mem, r_hlt_mem;
   logic [REG_ADDR_W-1:0] r_addr_mem;
   // MEM/WB slot
   logic                  r_vld_wb, r_rw_wb, r_m2r_wb;
   logic [REG_ADDR_W-1:0] r_addr_wb;

   logic w_lu_raw;
   logic w_advance;
   logic w_issue;

   // Load-use: a valid load in EX whose destination (other than R0) is read
   // by the ID instruction. A flush kills the ID instruction, so no stall.
   assign w_lu_raw = (HAZARD_EN != 0) && r_vld_ex && r_m2r_ex && r_rw_ex &&
                     (r_addr_ex != '0) &&
                     ((w_src1 && (rs_id == r_addr_ex)) || (w_src2 && (rt_id == r_addr_ex)));
   assign stall_lu  = w_lu_raw && !flush_id;

   assign w_advance = !stall_ext;

   // ID instruction enters EX only when not flushed, not load-use stalled,
   // not halted, and not a second HLT while the first one drains.
   assign w_issue = !flush_id && !stall_lu && (r_state != S_HALTED) &&
                    !((r_state == S_DRAIN) && w_hlt);

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         S_RUN: begin
            if (w_advance && w_issue && w_hlt) w_state_nxt = S_DRAIN;
         end
         S_DRAIN: begin
            if (w_advance) begin
               if (HALT_DRAIN != 0) begin
                  // HLT moves MEM -> WB on this edge
                  if (r_vld_mem && r_hlt_mem) w_state_nxt = S_HALTED;
               end else begin
                  w_state_nxt = S_HALTED;
               end
            end
         end
         S_HALTED: w_state_nxt = S_HALTED;
         default:  w_state_nxt = S_RUN;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= S_RUN;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_vld_ex   <= 1'b0;
         r_rw_ex    <= 1'b0;
         r_m2r_ex   <= 1'b0;
         r_mw_ex    <= 1'b0;
         r_hlt_ex   <= 1'b0;
         r_addr_ex  <= '0;
         r_vld_mem  <= 1'b0;
         r_rw_mem   <= 1'b0;
         r_m2r_mem  <= 1'b0;
         r_mw_mem   <= 1'b0;
         r_hlt_mem  <= 1'b0;
         r_addr_mem <= '0;
         r_vld_wb   <= 1'b0;
         r_rw_wb    <= 1'b0;
         r_m2r_wb   <= 1'b0;
         r_addr_wb  <= '0;
      end else if (w_advance) begin
         // ID -> EX (bubble when not issuing)
         r_vld_ex   <= w_issue;
         r_rw_ex    <= w_issue & w_rw;
         r_m2r_ex   <= w_issue & w_m2r;
         r_mw_ex    <= w_issue & w_mw;
         r_hlt_ex   <= w_issue & w_hlt;
         r_addr_ex  <= w_issue ? rd_id : '0;
         // EX -> MEM
         r_vld_mem  <= r_vld_ex;
         r_rw_mem   <= r_rw_ex;
         r_m2r_mem  <= r_m2r_ex;
         r_mw_mem   <= r_mw_ex;
         r_hlt_mem  <= r_hlt_ex;
         r_addr_mem <= r_addr_ex;
         // MEM -> WB
         r_vld_wb   <= r_vld_mem;
         r_rw_wb    <= r_rw_mem;
         r_m2r_wb   <= r_m2r_mem;
         r_addr_wb  <= r_addr_mem;
      end
   end

   assign reg_write_ex  = r_vld_ex  & r_rw_ex;
   assign reg_write_mem = r_vld_mem & r_rw_mem;
   assign reg_write_wb  = r_vld_wb  & r_rw_wb;
   assign mem_write_mem = r_vld_mem & r_mw_mem;
   assign mem_to_reg_wb = r_vld_wb  & r_m2r_wb;
   assign wr_addr_ex    = r_vld_ex  ? r_addr_ex  : '0;
   assign wr_addr_mem   = r_vld_mem ? r_addr_mem : '0;
   assign wr_addr_wb    = r_vld_wb  ? r_addr_wb  : '0;

   assign hlt_pend = (r_state != S_RUN);
   assign halted   = (r_state == S_HALTED);

endmodule

// File: tb/tb_ctrl_pipe_unit.sv
module tb_ctrl_pipe_unit;

   localparam int AW  = 4;
   localparam int HAZ = 1;
   localparam int HD  = 1;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic [3:0]    opcode_id = 4'hC;
   logic [AW-1:0] rs_id = '0;
   logic [AW-1:0] rt_id = '0;
   logic [AW-1:0] rd_id = '0;
   logic          flush_id = 1'b0;
   logic          stall_ext = 1'b0;

   logic          stall_lu, hlt_pend, halted;
   logic          reg_write_ex, reg_write_mem, reg_write_wb;
   logic          mem_write_mem, mem_to_reg_wb;
   logic [AW-1:0] wr_addr_ex, wr_addr_mem, wr_addr_wb;

   ctrl_pipe_unit #(.REG_ADDR_W(AW), .HAZARD_EN(HAZ), .HALT_DRAIN(HD)) dut (
      .clk(clk), .rst_n(rst_n), .opcode_id(opcode_id), .rs_id(rs_id), .rt_id(rt_id),
      .rd_id(rd_id), .flush_id(flush_id), .stall_ext(stall_ext), .stall_lu(stall_lu),
      .hlt_pend(hlt_pend), .halted(halted), .reg_write_ex(reg_write_ex),
      .reg_write_mem(reg_write_mem), .reg_write_wb(reg_write_wb),
      .mem_write_mem(mem_write_mem), .mem_to_reg_wb(mem_to_reg_wb),
      .wr_addr_ex(wr_addr_ex), .wr_addr_mem(wr_addr_mem), .wr_addr_wb(wr_addr_wb)
   );

   always #5 clk = ~clk;

   // Reference model: the instructions sitting in EX, MEM, WB (index 0..2),
   // plus a halt mode (0 run, 1 draining, 2 halted) and a drain counter.
   typedef struct packed {
      logic          v;
      logic [3:0]    op;
      logic [AW-1:0] rd;
   } slot_t;

   slot_t pipe [3];
   int    mode;
   int    drain_cnt;

   // Bit n set = opcode n has the property
   logic [15:0] writes_tbl = 16'h4DFF;
   logic [15:0] src1_tbl   = 16'h2FFF;
   logic [15:0] src2_tbl   = 16'h028F;

   int n_assert = 0;
   int n_fail   = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      for (int i = 0; i < 3; i++) pipe[i] = '0;
      mode      = 0;
      drain_cnt = 0;
   endtask

   function automatic logic m_lu();
      slot_t e;
      e = pipe[0];
      return (HAZ != 0) && e.v && (e.op == 4'd8) && (e.rd != '0) && !flush_id &&
             ((src1_tbl[opcode_id] && (rs_id == e.rd)) || (src2_tbl[opcode_id] && (rt_id == e.rd)));
   endfunction

   task automatic model_edge();
      logic lu, enter;
      int   old;
      if (stall_ext) return;
      lu    = m_lu();
      enter = !flush_id && !lu && (mode != 2) && !((mode == 1) && (opcode_id == 4'hF));
      old   = mode;
      if (old == 1) begin
         drain_cnt++;
         if (drain_cnt == ((HD != 0) ? 2 : 1)) mode = 2;
      end
      if ((old == 0) && enter && (opcode_id == 4'hF)) begin
         mode      = 1;
         drain_cnt = 0;
      end
      pipe[2] = pipe[1];
      pipe[1] = pipe[0];
      pipe[0] = enter ? slot_t'{1'b1, opcode_id, rd_id} : slot_t'('0);
   endtask

   function automatic logic [AW-1:0] m_addr(input int i);
      return pipe[i].v ? pipe[i].rd : '0;
   endfunction

   task automatic check_all(input string where);
      chk({where, " reg_write_ex"},  32'(reg_write_ex),  32'(pipe[0].v & writes_tbl[pipe[0].op]));
      chk({where, " reg_write_mem"}, 32'(reg_write_mem), 32'(pipe[1].v & writes_tbl[pipe[1].op]));
      chk({where, " reg_write_wb"},  32'(reg_write_wb),  32'(pipe[2].v & writes_tbl[pipe[2].op]));
      chk({where, " mem_write_mem"}, 32'(mem_write_mem), 32'(pipe[1].v && (pipe[1].op == 4'd9)));
      chk({where, " mem_to_reg_wb"}, 32'(mem_to_reg_wb), 32'(pipe[2].v && (pipe[2].op == 4'd8)));
      chk({where, " wr_addr_ex"},    32'(wr_addr_ex),    32'(m_addr(0)));
      chk({where, " wr_addr_mem"},   32'(wr_addr_mem),   32'(m_addr(1)));
      chk({where, " wr_addr_wb"},    32'(wr_addr_wb),    32'(m_addr(2)));
      chk({where, " hlt_pend"},      32'(hlt_pend),      32'(mode != 0));
      chk({where, " halted"},        32'(halted),        32'(mode == 2));
      chk({where, " stall_lu"},      32'(stall_lu),      32'(m_lu()));
   endtask

   // One clock: drive ID inputs, check the combinational stall, clock, check state.
   task automatic cycle(input logic [3:0] op, input logic [AW-1:0] rs, input logic [AW-1:0] rt,
                        input logic [AW-1:0] rd, input logic fl, input logic sx, input string tag);
      opcode_id = op; rs_id = rs; rt_id = rt; rd_id = rd; flush_id = fl; stall_ext = sx;
      #1;
      chk({tag, " pre stall_lu"}, 32'(stall_lu), 32'(m_lu()));
      @(posedge clk);
      model_edge();
      #1;
      check_all(tag);
   endtask

   task automatic idle();
      cycle(4'hC, '0, '0, '0, 1'b0, 1'b0, "idle");
   endtask

   task automatic async_reset(input string tag);
      rst_n = 1'b0;
      model_reset();
      #1;
      check_all(tag);
      chk({tag, " halted0"},    32'(halted),     32'd0);
      chk({tag, " wr_addr_wb0"}, 32'(wr_addr_wb), 32'd0);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
   endtask

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [3:0]    rop;
      logic [AW-1:0] rrs, rrt, rrd;
      logic          rfl, rsx;

      model_reset();
      #2;
      check_all("reset");
      chk("reset reg_write_ex", 32'(reg_write_ex), 32'd0);
      chk("reset hlt_pend",     32'(hlt_pend),     32'd0);
      @(posedge clk);
      #1;
      rst_n = 1'b1;

      // ADD r1 travels EX -> MEM -> WB
      cycle(4'h0, 4'd2, 4'd3, 4'd1, 1'b0, 1'b0, "t1 add");
      chk("t1 rw_ex@1", 32'(reg_write_ex), 32'd1);
      idle();
      chk("t1 rw_mem@2", 32'(reg_write_mem), 32'd1);
      idle();
      chk("t1 rw_wb@3", 32'(reg_write_wb), 32'd1);
      chk("t1 addr_wb@3", 32'(wr_addr_wb), 32'd1);

      // LW r3 then ADD rs=3: one stall cycle, then ADD issues
      cycle(4'h8, 4'd0, 4'd0, 4'd3, 1'b0, 1'b0, "t2 lw");
      opcode_id = 4'h0; rs_id = 4'd3; rt_id = 4'd0; rd_id = 4'd4;
      #1;
      chk("t2 stall_lu", 32'(stall_lu), 32'd1);
      cycle(4'h0, 4'd3, 4'd0, 4'd4, 1'b0, 1'b0, "t2 add stalled");
      chk("t2 bubble_ex", 32'(reg_write_ex), 32'd0);
      cycle(4'h0, 4'd3, 4'd0, 4'd4, 1'b0, 1'b0, "t2 add retry");
      chk("t2 add_ex", 32'(wr_addr_ex), 32'd4);
      // load into R0 never stalls
      cycle(4'h8, 4'd0, 4'd0, 4'd0, 1'b0, 1'b0, "t2 lw r0");
      cycle(4'h0, 4'd0, 4'd0, 4'd5, 1'b0, 1'b0, "t2 add rs0");
      chk("t2 r0 nostall", 32'(wr_addr_ex), 32'd5);

      // SW: MemWrite in MEM, no RegWrite; flushed SW never writes
      cycle(4'h9, 4'd1, 4'd2, 4'd2, 1'b0, 1'b0, "t3 sw");
      idle();
      chk("t3 mw_mem@2", 32'(mem_write_mem), 32'd1);
      chk("t3 rw_mem", 32'(reg_write_mem), 32'd0);
      cycle(4'h9, 4'd1, 4'd2, 4'd2, 1'b1, 1'b0, "t3 sw flush");
      idle();
      chk("t3 flushed mw", 32'(mem_write_mem), 32'd0);

      // External stall with a load in MEM
      cycle(4'h8, 4'd0, 4'd0, 4'd6, 1'b0, 1'b0, "t4 lw");
      idle();
      for (int i = 0; i < 3; i++) begin
         rop = 4'($urandom_range(0, 14));
         cycle(rop, 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)), 4'd7, 1'b0, 1'b1, "t4 stall");
         chk("t4 held addr_mem", 32'(wr_addr_mem), 32'd6);
      end
      idle();
      chk("t4 m2r_wb", 32'(mem_to_reg_wb), 32'd1);

      // HLT behind ADD: drain, then halt; later instructions ignored
      cycle(4'h0, 4'd1, 4'd1, 4'd7, 1'b0, 1'b0, "t5 add");
      cycle(4'hF, 4'd0, 4'd0, 4'd0, 1'b0, 1'b0, "t5 hlt");
      chk("t5 hlt_pend@1", 32'(hlt_pend), 32'd1);
      cycle(4'h0, 4'd1, 4'd1, 4'd9, 1'b0, 1'b0, "t5 drain1");
      chk("t5 add retired", 32'(wr_addr_wb), 32'd7);
      chk("t5 not yet halted", 32'(halted), 32'd0);
      cycle(4'h0, 4'd1, 4'd1, 4'd9, 1'b0, 1'b0, "t5 drain2");
      chk("t5 halted@3", 32'(halted), 32'd1);
      for (int i = 0; i < 3; i++) begin
         cycle(4'h0, 4'd1, 4'd1, 4'd9, 1'b0, 1'b0, "t5 after");
         chk("t5 ignored", 32'(reg_write_ex), 32'd0);
      end

      // Reset while HLT is in MEM
      async_reset("t6 clear");
      cycle(4'hF, 4'd0, 4'd0, 4'd0, 1'b0, 1'b0, "t6 hlt");
      idle();
      async_reset("t6 rst");
      chk("t6 hlt_pend", 32'(hlt_pend), 32'd0);
      cycle(4'h0, 4'd1, 4'd1, 4'd1, 1'b0, 1'b0, "t6 alive");
      chk("t6 rw_ex", 32'(reg_write_ex), 32'd1);

      // Randomized traffic against the model
      for (int s = 0; s < 6; s++) begin
         for (int k = 0; k < 300; k++) begin
            rop = 4'($urandom_range(0, 14));
            if ($urandom_range(0, 59) == 0) rop = 4'hF;
            rrs = 4'($urandom_range(0, 3));
            rrt = 4'($urandom_range(0, 3));
            rrd = 4'($urandom_range(0, 3));
            rfl = ($urandom_range(0, 7) == 0);
            rsx = ($urandom_range(0, 7) == 0);
            cycle(rop, rrs, rrt, rrd, rfl, rsx, "rand");
         end
         async_reset("rand rst");
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
